// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the CPU-to-block-RAM access controller.
// The error check lives here so the FSM and any future users classify requests identically.
package mem_ctrl_pkg;

  localparam int RAM_AW = 11;
  localparam int RAM_DW = 32;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    RD_DATA,
    WR,
    RMW_RD,
    RMW_WR,
    RESP
  } state_t;

  // Illegal size, misalignment, or an address beyond the 8 KiB RAM window.
  function automatic logic req_is_err(input logic [1:0] size, input logic [31:0] addr);
    logic e;
    e = (addr[31:13] != '0);
    case (size)
      SZ_BYTE: e = e;
      SZ_HALF: e = e | addr[0];
      SZ_WORD: e = e | (|addr[1:0]);
      default: e = 1'b1;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Little-endian lane handling: extracts and extends sub-word loads, and merges
// sub-word store data into the word read back for read-modify-write.
module mem_lane_align
  import mem_ctrl_pkg::*;
(
  input  logic [1:0]        i_addr_lo,
  input  logic [1:0]        i_size,
  input  logic              i_sign_ext,
  input  logic [RAM_DW-1:0] i_rdata,
  input  logic [15:0]       i_wdata,
  output logic [RAM_DW-1:0] o_load_data,
  output logic [RAM_DW-1:0] o_merge_data
);

  logic [15:0] w_shift;

  assign w_shift = 16'(i_rdata >> {i_addr_lo, 3'b000});

  always_comb begin
    o_load_data = i_rdata;
    case (i_size)
      SZ_BYTE: o_load_data = {{24{i_sign_ext & w_shift[7]}}, w_shift[7:0]};
      SZ_HALF: o_load_data = {{16{i_sign_ext & w_shift[15]}}, w_shift[15:0]};
      default: o_load_data = i_rdata;
    endcase
  end

  // Halfword stores put wdata[15:8] into the odd lane of the selected pair.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    localparam logic [1:0] LANE = 2'(gi);
    logic w_hit;
    assign w_hit = ((i_size == SZ_BYTE) && (i_addr_lo == LANE)) ||
                   ((i_size == SZ_HALF) && (i_addr_lo[1] == LANE[1]));
    assign o_merge_data[8*gi +: 8] = w_hit ?
        (((i_size == SZ_HALF) && LANE[0]) ? i_wdata[15:8] : i_wdata[7:0]) :
        i_rdata[8*gi +: 8];
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Single-request CPU load/store controller in front of a 2K x 32 synchronous-read RAM.
// Sub-word stores are done as read-modify-write since the RAM has no byte enables.
module mem_access_ctrl
  import mem_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic              resp_err,
  output logic [31:0]       resp_rdata,
  output logic              ram_we,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [RAM_DW-1:0] ram_din,
  input  logic [RAM_DW-1:0] ram_dout
);

  state_t      r_state;
  logic [1:0]  r_size;
  logic        r_signed;
  logic [12:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_resp_valid;
  logic        r_resp_err;
  logic [31:0] r_resp_rdata;

  logic              w_req_err;
  logic [RAM_DW-1:0] w_load_data;
  logic [RAM_DW-1:0] w_merge_data;

  assign w_req_err = req_is_err(req_size, req_addr);

  mem_lane_align u_align (
    .i_addr_lo   (r_addr[1:0]),
    .i_size      (r_size),
    .i_sign_ext  (r_signed),
    .i_rdata     (ram_dout),
    .i_wdata     (r_wdata[15:0]),
    .o_load_data (w_load_data),
    .o_merge_data(w_merge_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_size       <= SZ_BYTE;
      r_signed     <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= '0;
    end else begin
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      case (r_state)
        IDLE: if (req_valid) begin
          r_size   <= req_size;
          r_signed <= req_signed;
          r_addr   <= req_addr[12:0];
          r_wdata  <= req_wdata;
          if (w_req_err) begin
            r_state      <= RESP;
            r_resp_valid <= 1'b1;
            r_resp_err   <= 1'b1;
          end else if (!req_we)         r_state <= RD;
          else if (req_size == SZ_WORD) r_state <= WR;
          else                          r_state <= RMW_RD;
        end
        RD:      r_state <= RD_DATA;
        RD_DATA: begin
          r_resp_rdata <= w_load_data;
          r_resp_valid <= 1'b1;
          r_state      <= RESP;
        end
        WR, RMW_WR: begin
          r_resp_valid <= 1'b1;
          r_state      <= RESP;
        end
        RMW_RD:  r_state <= RMW_WR;
        RESP:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // RAM read data arrives in RMW_WR, so the write side is decoded from state rather than pre-registered.
  always_comb begin
    ram_din = '0;
    case (r_state)
      WR:      ram_din = r_wdata;
      RMW_WR:  ram_din = w_merge_data;
      default: ram_din = '0;
    endcase
  end

  assign ram_we     = !rst && ((r_state == WR) || (r_state == RMW_WR));
  assign ram_addr   = r_addr[12:2];
  assign req_ready  = (r_state == IDLE);
  assign resp_valid = r_resp_valid;
  assign resp_err   = r_resp_err;
  assign resp_rdata = r_resp_rdata;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a behavioural 1-cycle-read RAM model.
module tb_mem_access_ctrl;
  import mem_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = SZ_WORD;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;
  logic        ram_we;
  logic [10:0] ram_addr;
  logic [31:0] ram_din;
  logic [31:0] ram_dout;

  logic [31:0] mem [0:2047];
  int          we_cnt = 0;
  int          acc_cnt = 0;
  logic [10:0] last_we_addr = '0;
  int          n_pass = 0;
  int          n_total = 0;

  mem_access_ctrl dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_size(req_size), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_err(resp_err), .resp_rdata(resp_rdata), .ram_we(ram_we),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_we) begin
      mem[ram_addr] <= ram_din;
      we_cnt        <= we_cnt + 1;
      last_we_addr  <= ram_addr;
    end
    ram_dout <= mem[ram_addr];
    if (req_valid && req_ready) acc_cnt <= acc_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // One request from a negedge in IDLE; returns at the negedge of the following IDLE cycle.
  task automatic xact(input logic we, input logic [1:0] sz, input logic sg,
                      input logic [31:0] addr, input logic [31:0] wd,
                      output int lat, output logic err, output logic [31:0] rd, output int wep);
    int we0;
    we0 = we_cnt;
    req_we = we; req_size = sz; req_signed = sg; req_addr = addr; req_wdata = wd;
    req_valid = 1'b1;
    chk("ready_before", 32'(req_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; req_we = ~we; req_size = ~sz; req_signed = ~sg;
    req_addr = 32'hFFFF_FFFF; req_wdata = 32'h0;
    lat = 1;
    while (!resp_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    err = resp_err;
    rd  = resp_rdata;
    @(negedge clk);
    wep = we_cnt - we0;
    chk("resp_one_cycle", 32'(resp_valid), 32'd0);
    $display("xact we=%0b size=%0d signed=%0b addr=%h wdata=%h -> lat=%0d err=%0b rdata=%h we_pulses=%0d",
             we, sz, sg, addr, wd, lat, err, rd, wep);
  endtask

  initial begin
    int lat, wep, k, nr, cyc, seen, we0, acc0;
    logic err;
    logic [31:0] rd;
    logic [31:0] qaddr [4];
    logic [31:0] qdata [4];
    int          rc [4];
    logic [31:0] rq [4];
    qaddr = '{32'h50, 32'h54, 32'h58, 32'h5C};
    qdata = '{32'h1111_0001, 32'h2222_0002, 32'h3333_0003, 32'h4444_0004};

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    chk("rst_ram_we", 32'(ram_we), 32'd0);
    chk("rst_ram_addr", 32'(ram_addr), 32'd0);
    chk("rst_ram_din", ram_din, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    xact(1, SZ_WORD, 0, 32'h40, 32'hDEADBEEF, lat, err, rd, wep);
    chk("sw_lat", lat, 2); chk("sw_err", 32'(err), 0); chk("sw_we", wep, 1);
    chk("sw_we_addr", 32'(last_we_addr), 32'h010); chk("sw_mem", mem[16], 32'hDEADBEEF);

    xact(0, SZ_WORD, 0, 32'h40, 32'h0, lat, err, rd, wep);
    chk("lw_lat", lat, 3); chk("lw_data", rd, 32'hDEADBEEF); chk("lw_we", wep, 0);

    xact(1, SZ_BYTE, 0, 32'h42, 32'h0000_0055, lat, err, rd, wep);
    chk("sb_lat", lat, 3); chk("sb_we", wep, 1); chk("sb_mem", mem[16], 32'hDE55BEEF);

    xact(0, SZ_HALF, 1, 32'h42, 32'h0, lat, err, rd, wep);
    chk("lh_signed", rd, 32'hFFFFDE55);
    xact(0, SZ_HALF, 0, 32'h42, 32'h0, lat, err, rd, wep);
    chk("lh_unsigned", rd, 32'h0000DE55);
    xact(0, SZ_BYTE, 0, 32'h41, 32'h0, lat, err, rd, wep);
    chk("lb_unsigned", rd, 32'h0000_00BE);
    xact(0, SZ_BYTE, 1, 32'h41, 32'h0, lat, err, rd, wep);
    chk("lb_signed", rd, 32'hFFFF_FFBE);
    xact(0, SZ_BYTE, 1, 32'h43, 32'h0, lat, err, rd, wep);
    chk("lb3_signed", rd, 32'hFFFF_FFDE);

    xact(1, SZ_HALF, 0, 32'h40, 32'hAAAA_1234, lat, err, rd, wep);
    chk("sh_mem", mem[16], 32'hDE551234); chk("sh_lat", lat, 3);
    chk("rdata_hold_store", resp_rdata, 32'hFFFF_FFDE);
    xact(0, SZ_WORD, 0, 32'h40, 32'h0, lat, err, rd, wep);
    chk("lw2_data", rd, 32'hDE551234);

    xact(0, SZ_WORD, 0, 32'h41, 32'h0, lat, err, rd, wep);
    chk("err_mis_lat", lat, 1); chk("err_mis", 32'(err), 1); chk("err_mis_we", wep, 0);
    xact(0, 2'b11, 0, 32'h40, 32'h0, lat, err, rd, wep);
    chk("err_sz_lat", lat, 1); chk("err_sz", 32'(err), 1);
    xact(0, SZ_WORD, 0, 32'h2000, 32'h0, lat, err, rd, wep);
    chk("err_range_lat", lat, 1); chk("err_range", 32'(err), 1);
    xact(1, SZ_HALF, 0, 32'h41, 32'h0000_7777, lat, err, rd, wep);
    chk("err_st", 32'(err), 1); chk("err_st_we", wep, 0); chk("err_st_mem", mem[16], 32'hDE551234);
    chk("rdata_hold_err", resp_rdata, 32'hDE551234);

    // Reset while in RMW_RD of a byte store.
    we0 = we_cnt;
    req_we = 1; req_size = SZ_BYTE; req_signed = 0; req_addr = 32'h40; req_wdata = 32'hAA;
    req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rmwrst_ready", 32'(req_ready), 32'd1);
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      if (resp_valid) seen++;
      @(negedge clk);
    end
    chk("rmwrst_no_resp", seen, 0); chk("rmwrst_no_we", we_cnt - we0, 0);
    chk("rmwrst_mem", mem[16], 32'hDE551234);
    $display("xact reset-in-RMW_RD byte store addr=40 -> resp_seen=%0d we_pulses=%0d", seen, we_cnt - we0);

    // Reset while in WR must kill the write in that very cycle.
    we0 = we_cnt;
    req_we = 1; req_size = SZ_WORD; req_addr = 32'h40; req_wdata = 32'h1111_1111;
    req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("wr_we_high", 32'(ram_we), 32'd1);
    rst = 1'b1;
    #1;
    chk("wrrst_we_low", 32'(ram_we), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("wrrst_ready", 32'(req_ready), 32'd1); chk("wrrst_no_resp", 32'(resp_valid), 32'd0);
    chk("wrrst_mem", mem[16], 32'hDE551234); chk("wrrst_no_we", we_cnt - we0, 0);
    $display("xact reset-in-WR word store addr=40 -> mem=%h we_pulses=%0d", mem[16], we_cnt - we0);
    @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      xact(1, SZ_WORD, 0, qaddr[i], qdata[i], lat, err, rd, wep);
      chk("q_fill_lat", lat, 2);
    end

    // Four loads with req_valid held high; busy-cycle inputs are garbage and must be ignored.
    acc0 = acc_cnt;
    req_we = 0; req_size = SZ_WORD; req_signed = 0;
    k = 0; nr = 0; cyc = 0;
    while (nr < 4 && cyc < 60) begin
      if (resp_valid) begin
        rc[nr] = cyc;
        rq[nr] = resp_rdata;
        nr++;
      end
      if (req_ready) begin
        if (k < 4) begin
          req_valid = 1'b1;
          req_addr  = qaddr[k];
          k++;
        end else req_valid = 1'b0;
      end else req_addr = 32'hFFFF_FFF0;
      @(negedge clk);
      cyc++;
    end
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("q_responses", nr, 4);
    chk("q_accepts", acc_cnt - acc0, 4);
    for (int i = 0; i < 4; i++) begin
      chk("q_data", rq[i], qdata[i]);
      if (i > 0) chk("q_spacing", rc[i] - rc[i-1], 4);
      $display("xact queued load %0d addr=%h -> rdata=%h cycle=%0d", i, qaddr[i], rq[i], rc[i]);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
